// File: rtl/id_ex_stage.sv
// ============================================================================
// Module   : id_ex_stage
// Purpose  : ID/EX pipeline register with stall/flush, E-stage hazard info,
//            EX ALU control decode and a saturating bubble counter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module id_ex_stage #(
  parameter int          XLEN     = 32,
  parameter int          CNT_W    = 16,
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic             clr_cnt,
  input  logic [31:0]      D_I,
  input  logic [31:0]      D_PC,
  input  logic [XLEN-1:0]  D_RD1,
  input  logic [XLEN-1:0]  D_RD2,
  output logic [31:0]      E_I,
  output logic [31:0]      E_PC,
  output logic [XLEN-1:0]  E_RD1,
  output logic [XLEN-1:0]  E_RD2,
  output logic             E_valid,
  output logic [4:0]       E_A3,
  output logic [1:0]       E_TNEW,
  output logic             ExtOp,
  output logic             E_s,
  output logic [3:0]       E_ALUOP,
  output logic [CNT_W-1:0] bubble_cnt
);

  typedef enum logic [3:0] {
    K_NOP, K_ADDU, K_SUBU, K_AND, K_OR, K_SLT, K_JR, K_JALR,
    K_ORI, K_LW, K_SW, K_BEQ, K_LUI, K_JAL, K_J, K_ADDI
  } kind_e;

  function automatic kind_e classify(input logic [31:0] ins);
    kind_e k;
    k = K_NOP;
    case (ins[31:26])
      6'h00: begin
        case (ins[5:0])
          6'h21:   k = K_ADDU;
          6'h23:   k = K_SUBU;
          6'h24:   k = K_AND;
          6'h25:   k = K_OR;
          6'h2A:   k = K_SLT;
          6'h08:   k = K_JR;
          6'h09:   k = K_JALR;
          default: k = K_NOP;
        endcase
      end
      6'h0D:   k = K_ORI;
      6'h23:   k = K_LW;
      6'h2B:   k = K_SW;
      6'h04:   k = K_BEQ;
      6'h0F:   k = K_LUI;
      6'h03:   k = K_JAL;
      6'h02:   k = K_J;
      6'h08:   k = K_ADDI;
      default: k = K_NOP;
    endcase
    return k;
  endfunction

  logic [31:0]      e_i_q, e_pc_q;
  logic [XLEN-1:0]  e_rd1_q, e_rd2_q;
  logic             e_valid_q;
  logic [4:0]       e_a3_q, a3_d;
  logic [1:0]       e_tnew_q, tnew_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  kind_e            d_kind, e_kind;

  assign d_kind = classify(D_I);
  assign e_kind = classify(e_i_q);

  // Hazard info is decoded on the D side so forwarding reads it straight from flops
  always_comb begin
    a3_d   = 5'd0;
    tnew_d = 2'd0;
    case (d_kind)
      K_ADDU, K_SUBU, K_AND, K_OR, K_SLT: begin a3_d = D_I[15:11]; tnew_d = 2'd1; end
      K_JALR:                             a3_d = D_I[15:11];
      K_ORI, K_LUI, K_ADDI:               begin a3_d = D_I[20:16]; tnew_d = 2'd1; end
      K_LW:                               begin a3_d = D_I[20:16]; tnew_d = 2'd2; end
      K_JAL:                              a3_d = 5'd31;
      default: begin
        a3_d   = 5'd0;
        tnew_d = 2'd0;
      end
    endcase
  end

  always_comb begin
    ExtOp   = 1'b0;
    E_s     = 1'b0;
    E_ALUOP = 4'd0;
    case (e_kind)
      K_OR:          E_ALUOP = 4'd1;
      K_ORI:         begin E_ALUOP = 4'd1; E_s = 1'b1; end
      K_ADDU:        E_ALUOP = 4'd2;
      K_LW, K_SW,
      K_ADDI:        begin E_ALUOP = 4'd2; E_s = 1'b1; ExtOp = 1'b1; end
      K_SUBU:        E_ALUOP = 4'd3;
      K_BEQ:         begin E_ALUOP = 4'd3; ExtOp = 1'b1; end
      K_LUI:         begin E_ALUOP = 4'd4; E_s = 1'b1; end
      K_AND:         E_ALUOP = 4'd5;
      K_SLT:         E_ALUOP = 4'd6;
      default:       E_ALUOP = 4'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_i_q     <= 32'd0;
      e_pc_q    <= RESET_PC;
      e_rd1_q   <= '0;
      e_rd2_q   <= '0;
      e_valid_q <= 1'b0;
      e_a3_q    <= 5'd0;
      e_tnew_q  <= 2'd0;
    end else if (flush) begin
      // Bubble keeps the PC so a later exception can still be attributed
      e_i_q     <= 32'd0;
      e_pc_q    <= D_PC;
      e_rd1_q   <= '0;
      e_rd2_q   <= '0;
      e_valid_q <= 1'b0;
      e_a3_q    <= 5'd0;
      e_tnew_q  <= 2'd0;
    end else if (!stall) begin
      e_i_q     <= D_I;
      e_pc_q    <= D_PC;
      e_rd1_q   <= D_RD1;
      e_rd2_q   <= D_RD2;
      e_valid_q <= 1'b1;
      e_a3_q    <= a3_d;
      e_tnew_q  <= tnew_d;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (clr_cnt) begin
      cnt_d = '0;
    end else if (flush && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  logic unused_d_bits;
  assign unused_d_bits = ^{D_I[25:21], D_I[10:6]};

  assign E_I        = e_i_q;
  assign E_PC       = e_pc_q;
  assign E_RD1      = e_rd1_q;
  assign E_RD2      = e_rd2_q;
  assign E_valid    = e_valid_q;
  assign E_A3       = e_a3_q;
  assign E_TNEW     = e_tnew_q;
  assign bubble_cnt = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
// ============================================================================
// Module   : tb_id_ex_stage
// Purpose  : Directed and randomized self-checking bench for id_ex_stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_id_ex_stage;

  localparam int XLEN  = 32;
  localparam int CNT_W = 2;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk;
  logic             reset;
  logic             stall, flush, clr_cnt;
  logic [31:0]      d_i, d_pc;
  logic [XLEN-1:0]  d_rd1, d_rd2;
  logic [31:0]      E_I, E_PC;
  logic [XLEN-1:0]  E_RD1, E_RD2;
  logic             E_valid, ExtOp, E_s;
  logic [4:0]       E_A3;
  logic [1:0]       E_TNEW;
  logic [3:0]       E_ALUOP;
  logic [CNT_W-1:0] bubble_cnt;

  int n_checks;
  int n_fail;

  id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W), .RESET_PC(32'h0000_3000)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .clr_cnt(clr_cnt),
    .D_I(d_i), .D_PC(d_pc), .D_RD1(d_rd1), .D_RD2(d_rd2),
    .E_I(E_I), .E_PC(E_PC), .E_RD1(E_RD1), .E_RD2(E_RD2),
    .E_valid(E_valid), .E_A3(E_A3), .E_TNEW(E_TNEW),
    .ExtOp(ExtOp), .E_s(E_s), .E_ALUOP(E_ALUOP), .bubble_cnt(bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction attribute table: a3 source 0=none 1=rd 2=rt 3=$31
  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    bit         rtype;
    int         a3src;
    int         tnew;
    bit         ext;
    bit         s;
    int         alu;
  } desc_t;

  desc_t tbl[15];

  task automatic init_table();
    tbl[0]  = '{6'h00, 6'h21, 1, 1, 1, 0, 0, 2};
    tbl[1]  = '{6'h00, 6'h23, 1, 1, 1, 0, 0, 3};
    tbl[2]  = '{6'h00, 6'h24, 1, 1, 1, 0, 0, 5};
    tbl[3]  = '{6'h00, 6'h25, 1, 1, 1, 0, 0, 1};
    tbl[4]  = '{6'h00, 6'h2A, 1, 1, 1, 0, 0, 6};
    tbl[5]  = '{6'h00, 6'h08, 1, 0, 0, 0, 0, 0};
    tbl[6]  = '{6'h00, 6'h09, 1, 1, 0, 0, 0, 0};
    tbl[7]  = '{6'h0D, 6'h00, 0, 2, 1, 0, 1, 1};
    tbl[8]  = '{6'h23, 6'h00, 0, 2, 2, 1, 1, 2};
    tbl[9]  = '{6'h2B, 6'h00, 0, 0, 0, 1, 1, 2};
    tbl[10] = '{6'h04, 6'h00, 0, 0, 0, 1, 0, 3};
    tbl[11] = '{6'h0F, 6'h00, 0, 2, 1, 0, 1, 4};
    tbl[12] = '{6'h03, 6'h00, 0, 3, 0, 0, 0, 0};
    tbl[13] = '{6'h02, 6'h00, 0, 0, 0, 0, 0, 0};
    tbl[14] = '{6'h08, 6'h00, 0, 2, 1, 1, 1, 2};
  endtask

  task automatic model_decode(input logic [31:0] ins, output logic [4:0] a3,
                              output logic [1:0] tnew, output logic ext,
                              output logic s, output logic [3:0] alu);
    a3 = 0; tnew = 0; ext = 0; s = 0; alu = 0;
    for (int k = 0; k < 15; k++) begin
      if (ins[31:26] == tbl[k].op && (!tbl[k].rtype || ins[5:0] == tbl[k].fn)) begin
        case (tbl[k].a3src)
          1:       a3 = ins[15:11];
          2:       a3 = ins[20:16];
          3:       a3 = 5'd31;
          default: a3 = 5'd0;
        endcase
        tnew = tbl[k].tnew[1:0];
        ext  = tbl[k].ext;
        s    = tbl[k].s;
        alu  = tbl[k].alu[3:0];
      end
    end
  endtask

  logic [31:0]     m_i, m_pc;
  logic [XLEN-1:0] m_rd1, m_rd2;
  logic            m_valid;
  logic [4:0]      m_a3;
  logic [1:0]      m_tnew;
  int              m_cnt;

  task automatic model_reset();
    m_i = 0; m_pc = 32'h3000; m_rd1 = 0; m_rd2 = 0;
    m_valid = 0; m_a3 = 0; m_tnew = 0; m_cnt = 0;
  endtask

  task automatic model_step();
    logic [4:0] a3; logic [1:0] tn; logic ex, s; logic [3:0] al;
    model_decode(d_i, a3, tn, ex, s, al);
    if (clr_cnt) m_cnt = 0;
    else if (flush && m_cnt < CMAX) m_cnt = m_cnt + 1;
    if (flush) begin
      m_i = 0; m_rd1 = 0; m_rd2 = 0; m_a3 = 0; m_tnew = 0; m_valid = 0; m_pc = d_pc;
    end else if (!stall) begin
      m_i = d_i; m_pc = d_pc; m_rd1 = d_rd1; m_rd2 = d_rd2;
      m_valid = 1; m_a3 = a3; m_tnew = tn;
    end
  endtask

  // Advance one clock with the model in lockstep; returns #1 after the edge
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] ins, input logic [31:0] pc,
                       input logic f, input logic st, input logic c);
    d_i = ins; d_pc = pc; flush = f; stall = st; clr_cnt = c;
    d_rd1 = $urandom; d_rd2 = $urandom;
  endtask

  task automatic test_reset();
    drive(32'h8C82_0004, 32'h3040, 1'b1, 1'b0, 1'b0);
    cycle();
    drive(32'h8C82_0004, 32'h3044, 1'b0, 1'b0, 1'b0);
    cycle();
    #3;
    reset = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if ({E_I, E_PC, E_RD1, E_RD2} !== {32'h0, 32'h3000, 32'h0, 32'h0}) begin
      n_fail++;
      $display("FAIL reset_data: got I=%h PC=%h RD1=%h RD2=%h want 0/3000/0/0", E_I, E_PC, E_RD1, E_RD2);
    end
    n_checks++;
    if ({E_valid, E_A3, E_TNEW, bubble_cnt, ExtOp, E_s, E_ALUOP} !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got v=%b a3=%0d tn=%0d cnt=%0d ext=%b s=%b alu=%0d want all 0",
               E_valid, E_A3, E_TNEW, bubble_cnt, ExtOp, E_s, E_ALUOP);
    end
    @(negedge clk);
    reset = 1'b1;
    drive(32'h0085_1821, 32'h3000, 1'b0, 1'b0, 1'b0);
    cycle();
    n_checks++;
    if ({E_A3, E_TNEW, E_ALUOP, E_s, E_valid} !== {5'd3, 2'd1, 4'd2, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_first_load: got a3=%0d tn=%0d alu=%0d s=%b v=%b want 3/1/2/0/1",
               E_A3, E_TNEW, E_ALUOP, E_s, E_valid);
    end
  endtask

  task automatic test_load_lw();
    drive(32'h8C82_0004, 32'h3004, 1'b0, 1'b0, 1'b0);
    d_rd1 = 32'h100;
    cycle();
    n_checks++;
    if ({E_A3, E_TNEW, ExtOp, E_s, E_ALUOP, E_PC, E_RD1} !==
        {5'd2, 2'd2, 1'b1, 1'b1, 4'd2, 32'h3004, 32'h100}) begin
      n_fail++;
      $display("FAIL load_lw: got a3=%0d tn=%0d ext=%b s=%b alu=%0d pc=%h rd1=%h want 2/2/1/1/2/3004/100",
               E_A3, E_TNEW, ExtOp, E_s, E_ALUOP, E_PC, E_RD1);
    end
  endtask

  task automatic test_stall();
    logic [CNT_W-1:0] cnt0;
    drive(32'h3401_00FF, 32'h3008, 1'b0, 1'b0, 1'b0);
    cycle();
    cnt0 = bubble_cnt;
    for (int k = 0; k < 3; k++) begin
      drive($urandom, $urandom, 1'b0, 1'b1, 1'b0);
      cycle();
      n_checks++;
      if ({E_I, E_A3, E_ALUOP, bubble_cnt} !== {32'h3401_00FF, 5'd1, 4'd1, cnt0}) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: got I=%h a3=%0d alu=%0d cnt=%0d want 340100ff/1/1/%0d",
                 k, E_I, E_A3, E_ALUOP, bubble_cnt, cnt0);
      end
    end
  endtask

  task automatic test_flush();
    drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    cycle();
    for (int k = 0; k < 2; k++) begin
      drive(32'h0085_1821, 32'h3010, 1'b1, (k == 1), 1'b0);
      cycle();
      n_checks++;
      if ({E_I, E_valid, E_A3, E_TNEW, E_PC, bubble_cnt} !==
          {32'h0, 1'b0, 5'd0, 2'd0, 32'h3010, 2'(k + 1)}) begin
        n_fail++;
        $display("FAIL flush[%0d]: got I=%h v=%b a3=%0d tn=%0d pc=%h cnt=%0d want 0/0/0/0/3010/%0d",
                 k, E_I, E_valid, E_A3, E_TNEW, E_PC, bubble_cnt, k + 1);
      end
    end
  endtask

  task automatic test_saturation();
    logic [CNT_W-1:0] want [5];
    want[0] = 2'd1; want[1] = 2'd2; want[2] = 2'd3; want[3] = 2'd3; want[4] = 2'd3;
    drive(32'h0, 32'h3020, 1'b0, 1'b0, 1'b1);
    cycle();
    for (int k = 0; k < 5; k++) begin
      drive($urandom, 32'h3020, 1'b1, 1'b0, 1'b0);
      cycle();
      n_checks++;
      if (bubble_cnt !== want[k]) begin
        n_fail++;
        $display("FAIL sat_cnt[%0d]: got %0d want %0d", k, bubble_cnt, want[k]);
      end
    end
    drive($urandom, 32'h3024, 1'b1, 1'b0, 1'b1);
    cycle();
    n_checks++;
    if (bubble_cnt !== 2'd0) begin
      n_fail++;
      $display("FAIL sat_clear: got %0d want 0", bubble_cnt);
    end
  endtask

  task automatic test_jal_unknown();
    drive(32'h0C00_0C00, 32'h3030, 1'b0, 1'b0, 1'b0);
    cycle();
    n_checks++;
    if ({E_A3, E_TNEW, E_ALUOP} !== {5'd31, 2'd0, 4'd0}) begin
      n_fail++;
      $display("FAIL jal: got a3=%0d tn=%0d alu=%0d want 31/0/0", E_A3, E_TNEW, E_ALUOP);
    end
    drive(32'hFC00_0000, 32'h3034, 1'b0, 1'b0, 1'b0);
    cycle();
    n_checks++;
    if ({E_valid, E_A3, E_ALUOP, ExtOp} !== {1'b1, 5'd0, 4'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL unknown: got v=%b a3=%0d alu=%0d ext=%b want 1/0/0/0", E_valid, E_A3, E_ALUOP, ExtOp);
    end
    drive(32'h0, 32'h3038, 1'b0, 1'b0, 1'b0);
    cycle();
    n_checks++;
    if ({E_valid, E_A3, E_TNEW, E_ALUOP} !== {1'b1, 5'd0, 2'd0, 4'd0}) begin
      n_fail++;
      $display("FAIL zero_instr: got v=%b a3=%0d tn=%0d alu=%0d want 1/0/0/0", E_valid, E_A3, E_TNEW, E_ALUOP);
    end
  endtask

  task automatic test_random();
    logic [31:0] ins;
    logic [4:0] a3; logic [1:0] tn; logic ex, s; logic [3:0] al;
    int k;
    for (int n = 0; n < 400; n++) begin
      ins = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        k = $urandom_range(0, 14);
        ins[31:26] = tbl[k].op;
        if (tbl[k].rtype) ins[5:0] = tbl[k].fn;
      end
      drive(ins, $urandom, ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 15) == 0));
      cycle();
      model_decode(m_i, a3, tn, ex, s, al);
      n_checks++;
      if ({E_I, E_PC, E_RD1, E_RD2} !== {m_i, m_pc, m_rd1, m_rd2}) begin
        n_fail++;
        $display("FAIL rand_data[%0d]: got I=%h PC=%h RD1=%h RD2=%h want I=%h PC=%h RD1=%h RD2=%h",
                 n, E_I, E_PC, E_RD1, E_RD2, m_i, m_pc, m_rd1, m_rd2);
      end
      n_checks++;
      if ({E_valid, E_A3, E_TNEW, ExtOp, E_s, E_ALUOP, bubble_cnt} !==
          {m_valid, m_a3, m_tnew, ex, s, al, 2'(m_cnt)}) begin
        n_fail++;
        $display("FAIL rand_ctrl[%0d]: got v=%b a3=%0d tn=%0d ext=%b s=%b alu=%0d cnt=%0d want %b/%0d/%0d/%b/%b/%0d/%0d",
                 n, E_valid, E_A3, E_TNEW, ExtOp, E_s, E_ALUOP, bubble_cnt,
                 m_valid, m_a3, m_tnew, ex, s, al, m_cnt);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    init_table();
    model_reset();
    reset = 1'b0;
    drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    test_reset();
    test_load_lw();
    test_stall();
    test_flush();
    test_saturation();
    test_jal_unknown();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
